// File: rtl/issue_ctrl_if.sv
// Connects the decode stage, writeback stage and EU to issue_ctrl.
// Also carries read-only debug taps for the FSM state and FIFO occupancy.
interface issue_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Decode side: an instruction transfers on a rising edge where in_valid and
  // in_ready are both 1. in_valid may be raised at any time. in_ready never
  // waits on in_valid. The issue strobe is a push-only pulse with no back-pressure.
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [2:0]       in_dest;
  logic [2:0]       in_srcA;
  logic [2:0]       in_srcB;
  logic [3:0]       in_addr;
  logic             flush;
  logic             wb_valid;
  logic [2:0]       wb_dest;
  logic             iss_valid;
  logic [3:0]       iss_opcode;
  logic [2:0]       iss_dest;
  logic [2:0]       iss_srcA;
  logic [2:0]       iss_srcB;
  logic [3:0]       iss_addr;
  logic [7:0]       busy_mask;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       dbg_state;
  logic [CW-1:0]    dbg_count;

  modport master (
    output in_valid, in_opcode, in_dest, in_srcA, in_srcB, in_addr,
    output flush, wb_valid, wb_dest,
    input  in_ready, iss_valid, iss_opcode, iss_dest, iss_srcA, iss_srcB, iss_addr,
    input  busy_mask, stall_count, dbg_state, dbg_count
  );

  modport slave (
    input  in_valid, in_opcode, in_dest, in_srcA, in_srcB, in_addr,
    input  flush, wb_valid, wb_dest,
    output in_ready, iss_valid, iss_opcode, iss_dest, iss_srcA, iss_srcB, iss_addr,
    output busy_mask, stall_count, dbg_state, dbg_count
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue scheduler: an instruction FIFO and an 8-register write scoreboard.
// It issues one hazard-free instruction per cycle to the execution unit.
module issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         reset,
  issue_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] dest;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [3:0] addr;
  } instr_t;

  state_t           state, next_state;
  instr_t           mem [DEPTH];
  instr_t           head, iss_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       busy, eff_busy, wb_clr, iss_set;
  logic [CNT_W-1:0] stall_cnt;
  logic             iss_v;
  logic             is_nop, reads_a, reads_b, writes, hazard, enq, deq;

  assign bus.in_ready = (count < CW'(DEPTH)) && !bus.flush;

  always_comb begin
    head    = mem[rd_ptr];
    is_nop  = (head.opcode == 4'h0);
    reads_a = (head.opcode != 4'h0) && (head.opcode != 4'hE);
    reads_b = reads_a && (head.opcode != 4'hF);
    writes  = (head.opcode != 4'h0) && (head.opcode != 4'hF);
    // A same-cycle writeback frees its register for the head check.
    wb_clr   = bus.wb_valid ? (8'd1 << bus.wb_dest) : 8'd0;
    eff_busy = busy & ~wb_clr;
    hazard   = (reads_a && eff_busy[head.src_a]) ||
               (reads_b && eff_busy[head.src_b]) ||
               (writes  && eff_busy[head.dest]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= next_state;
  end

  always_comb begin
    next_state = EMPTY;
    if (!bus.flush && (count != '0)) next_state = hazard ? STALL : RUN;
    deq     = (next_state == RUN);
    enq     = bus.in_valid && bus.in_ready;
    iss_set = (deq && writes) ? (8'd1 << head.dest) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{opcode: bus.in_opcode, dest: bus.in_dest,
                              src_a: bus.in_srcA, src_b: bus.in_srcB,
                              addr: bus.in_addr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= '0;
      stall_cnt <= '0;
      iss_v     <= 1'b0;
      iss_q     <= '0;
    end else begin
      // Writeback clears before issue sets, so a same-register pair stays busy.
      busy <= (busy & ~wb_clr) | iss_set;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(enq) - CW'(deq);
      end
      iss_v <= deq && !is_nop;
      if (deq && !is_nop) iss_q <= head;
      if ((next_state == STALL) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.iss_valid   = iss_v;
  assign bus.iss_opcode  = iss_q.opcode;
  assign bus.iss_dest    = iss_q.dest;
  assign bus.iss_srcA    = iss_q.src_a;
  assign bus.iss_srcB    = iss_q.src_b;
  assign bus.iss_addr    = iss_q.addr;
  assign bus.busy_mask   = busy;
  assign bus.stall_count = stall_cnt;
  assign bus.dbg_state   = state;
  assign bus.dbg_count   = count;
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios with literal checks, plus a queue-based
// reference model that is compared against the DUT on every falling edge.
module tb_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] dest;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [3:0] addr;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  issue_ctrl_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [16:0] exp_q[$];
  logic [7:0]  m_busy = 8'd0;
  logic [7:0]  m_stall = 8'd0;
  logic        m_valid = 1'b0;
  ins_t        m_iss = '0;
  ins_t        m_h;
  logic [7:0]  m_bn;
  logic        m_take;

  function automatic logic [7:0] read_set(input ins_t i);
    case (i.opcode)
      4'h0, 4'hE: return 8'd0;
      4'hF:       return 8'd1 << i.src_a;
      default:    return (8'd1 << i.src_a) | (8'd1 << i.src_b);
    endcase
  endfunction

  function automatic logic [7:0] write_set(input ins_t i);
    if (i.opcode == 4'h0 || i.opcode == 4'hF) return 8'd0;
    return 8'd1 << i.dest;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_busy  = 8'd0;
      m_stall = 8'd0;
      m_valid = 1'b0;
      m_iss   = '0;
    end else begin
      m_take = bus.in_valid && (exp_q.size() < DEPTH) && !bus.flush;
      m_bn = m_busy;
      if (bus.wb_valid) m_bn[bus.wb_dest] = 1'b0;
      m_valid = 1'b0;
      if (bus.flush) begin
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        m_h = exp_q[0];
        if (((read_set(m_h) | write_set(m_h)) & m_bn) == 8'd0) begin
          void'(exp_q.pop_front());
          m_bn = m_bn | write_set(m_h);
          if (m_h.opcode != 4'h0) begin
            m_valid = 1'b1;
            m_iss   = m_h;
          end
        end else if (m_stall != 8'hFF) begin
          m_stall = m_stall + 8'd1;
        end
      end
      m_busy = m_bn;
      if (m_take) exp_q.push_back({bus.in_opcode, bus.in_dest, bus.in_srcA, bus.in_srcB, bus.in_addr});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("m_in_ready", bus.in_ready, (exp_q.size() < DEPTH) && !bus.flush);
    check("m_count", bus.dbg_count, exp_q.size());
    check("m_iss_valid", bus.iss_valid, m_valid);
    check("m_busy_mask", bus.busy_mask, m_busy);
    check("m_stall_count", bus.stall_count, m_stall);
    check("m_iss_fields", {bus.iss_opcode, bus.iss_dest, bus.iss_srcA, bus.iss_srcB, bus.iss_addr}, m_iss);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
  endtask

  task automatic offer(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [3:0] ad);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_dest   = d;
    bus.in_srcA   = a;
    bus.in_srcB   = b;
    bus.in_addr   = ad;
  endtask

  task automatic wb(input logic [2:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = r;
  endtask

  logic [3:0] f_op [5] = '{4'h1, 4'h2, 4'h4, 4'h6, 4'h8};
  logic [2:0] f_d  [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
  logic [2:0] f_a  [5] = '{3'd3, 3'd1, 3'd1, 3'd0, 3'd0};
  logic [2:0] f_b  [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};

  // ---------------- directed scenarios ----------------
  initial begin
    idle();
    bus.in_opcode = 4'h0;
    bus.in_dest   = 3'd0;
    bus.in_srcA   = 3'd0;
    bus.in_srcB   = 3'd0;
    bus.in_addr   = 4'h0;
    bus.wb_dest   = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_iss_valid", bus.iss_valid, 0);
    check("rst_busy", bus.busy_mask, 0);
    check("rst_stall", bus.stall_count, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // first issue latency
    offer(4'h3, 3'd2, 3'd0, 3'd1, 4'h0);
    tick();
    idle();
    check("lat_not_yet", bus.iss_valid, 0);
    tick();
    check("lat_iss_valid", bus.iss_valid, 1);
    check("lat_opcode", bus.iss_opcode, 4'h3);
    check("lat_dest", bus.iss_dest, 3'd2);
    check("lat_busy", bus.busy_mask, 8'b0000_0100);

    // RAW stall on r2, released by writeback bypass
    offer(4'h5, 3'd3, 3'd2, 3'd0, 4'h0);
    tick();
    idle();
    repeat (3) tick();
    check("raw_stall_cnt", bus.stall_count, 3);
    check("raw_iss_valid", bus.iss_valid, 0);
    wb(3'd2);
    tick();
    idle();
    check("raw_bypass_issue", bus.iss_valid, 1);
    check("raw_bypass_dest", bus.iss_dest, 3'd3);
    check("raw_busy", bus.busy_mask, 8'h08);

    // WAW+RAW on r3, writeback and reissue to r3 leaves bit3 set
    offer(4'h7, 3'd3, 3'd3, 3'd1, 4'h0);
    tick();
    idle();
    tick();
    wb(3'd3);
    tick();
    idle();
    check("waw_issue", bus.iss_opcode, 4'h7);
    check("waw_busy", bus.busy_mask, 8'h08);
    check("waw_stall_cnt", bus.stall_count, 4);

    // fill the FIFO behind a stalled head
    for (int i = 0; i < 5; i++) begin
      offer(f_op[i], f_d[i], f_a[i], f_b[i], 4'h0);
      check("full_in_ready", bus.in_ready, (i < 4) ? 1 : 0);
      tick();
    end
    idle();
    check("full_count", bus.dbg_count, 4);
    check("full_stall_cnt", bus.stall_count, 8);
    wb(3'd3);
    tick();
    idle();
    check("drain_valid_0", bus.iss_valid, 1);
    check("drain_dest_0", bus.iss_dest, f_d[0]);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("drain_valid", bus.iss_valid, 1);
      check("drain_dest", bus.iss_dest, f_d[k]);
    end
    tick();
    check("drain_done", bus.iss_valid, 0);
    check("drain_busy", bus.busy_mask, 8'hF0);
    for (int r = 4; r < 8; r++) begin
      wb(3'(r));
      tick();
      idle();
    end

    // NOP then STORE
    offer(4'h0, 3'd0, 3'd0, 3'd0, 4'h0);
    tick();
    offer(4'hF, 3'd0, 3'd3, 3'd0, 4'h9);
    tick();
    idle();
    check("nop_no_strobe", bus.iss_valid, 0);
    check("nop_consumed", bus.dbg_count, 1);
    tick();
    check("store_valid", bus.iss_valid, 1);
    check("store_opcode", bus.iss_opcode, 4'hF);
    check("store_addr", bus.iss_addr, 4'h9);
    check("store_busy", bus.busy_mask, 8'h00);
    tick();
    check("hold_valid", bus.iss_valid, 0);
    check("hold_addr", bus.iss_addr, 4'h9);

    // flush with three queued and r5 busy
    offer(4'h9, 3'd5, 3'd0, 3'd0, 4'h0);
    tick();
    idle();
    tick();
    check("flush_pre_busy", bus.busy_mask, 8'h20);
    for (int i = 0; i < 3; i++) begin
      offer(4'h1, 3'(i + 1), 3'd5, 3'd0, 4'h0);
      tick();
    end
    check("flush_pre_count", bus.dbg_count, 3);
    offer(4'h2, 3'd6, 3'd0, 3'd0, 4'h0);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    tick();
    idle();
    check("flush_count", bus.dbg_count, 0);
    check("flush_iss_valid", bus.iss_valid, 0);
    check("flush_busy", bus.busy_mask, 8'h20);
    tick();
    check("flush_dropped", bus.dbg_count, 0);

    // async reset in the middle of a stall
    offer(4'h1, 3'd1, 3'd5, 3'd0, 4'h0);
    tick();
    idle();
    repeat (2) tick();
    #3 reset = 1'b1;
    #1;
    check("arst_iss_valid", bus.iss_valid, 0);
    check("arst_busy", bus.busy_mask, 0);
    check("arst_stall", bus.stall_count, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_addr", bus.iss_addr, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // stall counter saturation
    offer(4'h2, 3'd1, 3'd0, 3'd0, 4'h0);
    tick();
    idle();
    tick();
    offer(4'h2, 3'd2, 3'd1, 3'd1, 4'h0);
    tick();
    idle();
    repeat (300) tick();
    check("sat_stall", bus.stall_count, 8'hFF);
    wb(3'd1);
    tick();
    idle();
    check("sat_release_dest", bus.iss_dest, 3'd2);
    check("sat_release_busy", bus.busy_mask, 8'h04);

    // flush and writeback on the same edge
    offer(4'h2, 3'd3, 3'd2, 3'd0, 4'h0);
    tick();
    idle();
    bus.flush = 1'b1;
    wb(3'd2);
    tick();
    idle();
    check("flush_wb_busy", bus.busy_mask, 8'h00);
    check("flush_wb_count", bus.dbg_count, 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- In-order instruction issue scheduler in front of the execution unit.
- Buffers decoded instructions in a small FIFO and tracks pending register writes in an 8-entry scoreboard.
- Issues one instruction per cycle to the EU, and only when it has no RAW or WAW hazard against in-flight results.
- The writeback stage retires scoreboard entries. Opcode map: 0000 NOP, 0001-1101 ALU, 1110 LOAD, 1111 STORE.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- CNT_W, 8: width of the saturating stall counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  FIFO can accept; combinational, equal to (count < DEPTH) and not flush.
- in_opcode  in  4  instruction opcode.
- in_dest  in  3  destination register.
- in_srcA  in  3  operand A register.
- in_srcB  in  3  operand B register.
- in_addr  in  4  data memory address (LOAD/STORE).
- flush  in  1  discard all queued instructions.
- wb_valid  in  1  writeback of a register this cycle.
- wb_dest  in  3  register being written back.
- iss_valid  out  1  registered one-cycle issue strobe to the EU.
- iss_opcode  out  4  issued opcode.
- iss_dest  out  3  issued destination.
- iss_srcA  out  3  issued operand A register.
- iss_srcB  out  3  issued operand B register.
- iss_addr  out  4  issued memory address.
- busy_mask  out  8  scoreboard; bit r=1 means a write to register r is pending.
- stall_count  out  CNT_W  cycles in STALL, saturating at all-ones.

Behaviour:
- Reset (async): FIFO emptied; busy_mask=0; stall_count=0; iss_valid=0; all iss_* fields=0; state=EMPTY. in_ready reads 1.
- Enqueue: on a clock edge where in_valid and in_ready are both 1. No pass-through when full, even if a dequeue happens in the same cycle.
- Read sets:
  - ALU ops read A and B.
  - STORE reads A.
  - LOAD and NOP read nothing.
- Write sets: ALU and LOAD write dest. STORE and NOP write nothing.
- Hazard at FIFO head: any of the following.
  - A read register has its busy bit set.
  - The written dest has its busy bit set (WAW).
- Effective busy = busy_mask with the bit for wb_dest cleared when wb_valid is 1 (same-cycle writeback bypass).
- States:
  - EMPTY: count==0.
  - RUN: head present, no hazard.
  - STALL: head present, hazard.
  - State is registered; it is evaluated every cycle from count and the effective hazard.
- RUN action, at the edge:
  - Dequeue the head.
  - Drive iss_* from the head.
  - Set the dest busy bit if the op writes.
  - If the head is a NOP, dequeue it with iss_valid=0; the NOP still consumes that cycle.
- STALL action: no dequeue; iss_valid=0 next cycle; stall_count+1, saturating.
- EMPTY action: iss_valid=0. iss_* fields hold their last value.
- Latency: an instruction enqueued at edge N into an empty, hazard-free controller appears with iss_valid=1 after edge N+1. Issue rate is at most one per cycle.
- Scoreboard update order within an edge: writeback clear first, then issue set. Same-register writeback and issue therefore leaves the bit set.
- A wb_valid for a register that is not busy is ignored.
- Flush:
  - At the edge, count=0 and iss_valid=0.
  - in_ready is 0 while flush is high; input on that cycle is dropped.
  - busy_mask is not cleared, because in-flight ops still write back.
  - flush and wb_valid in the same cycle: the writeback clear still applies.
- Reset mid-stall or mid-issue: everything clears at once; any pending writeback is lost.
- FIFO pointers wrap modulo DEPTH. count has log2(DEPTH)+1 bits.

Test Plan:
- Reset, then enqueue ALU op 0011 dest=2 srcA=0 srcB=1 → after next edge: iss_valid=1, iss_opcode=0011, iss_dest=2; busy_mask=00000100.
- RAW stall: with r2 busy, enqueue ALU srcA=2 → STALL. stall_count increments each cycle, iss_valid=0. Pulse wb_valid with wb_dest=2 → the op issues at that edge (bypass) and busy_mask bit2 is re-set only if the op's dest is 2.
- Full FIFO: DEPTH=4, head stalled, offer 5 instructions → 4 accepted; in_ready=0 on the 5th. After the hazard clears, the instructions issue in order on 4 consecutive cycles.
- NOP and STORE: enqueue 0000, then 1111 srcA=3 addr=9 → the NOP produces no strobe. The STORE issues with iss_addr=9 and busy_mask unchanged.
- Flush with 3 queued and r5 busy → next cycle: count=0, iss_valid=0, busy_mask bit5 still 1. in_valid during flush is not accepted.
- Async reset asserted mid-STALL without a clock edge → iss_valid=0, busy_mask=0, stall_count=0 immediately; in_ready=1. stall_count saturation check: hold a stall for 300 cycles → stall_count reads 255.
